// File: rtl/sync_down_timer_pkg.sv
// sync_down_pkg: shared state encoding and mode constants for sync_down_timer
package sync_down_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/sync_down_timer_down_next.sv
// down_next: combinational borrow-chain decrementer with an is-one flag
module down_next
    import sync_down_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] cnt_i,
    output logic [WIDTH-1:0] nxt_o,
    output logic             is_one_o
);

    logic [WIDTH-1:0] borrow;

    assign borrow[0] = 1'b1;

    // A bit toggles only when every lower bit is zero, so the borrow ripples upward.
    for (genvar i = 1; i < WIDTH; i++) begin : g_borrow
        assign borrow[i] = borrow[i-1] & ~cnt_i[i-1];
    end

    assign nxt_o    = cnt_i ^ borrow;
    assign is_one_o = (cnt_i == WIDTH'(1));

endmodule

// File: rtl/sync_down_timer.sv
// sync_down_timer: loadable down timer, one-shot or periodic, with registered terminal-count pulse.
// Defining SYNC_DOWN_TIMER_CASCADE_EN adds combinational tc_early for chaining stages.
module sync_down_timer
    import sync_down_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             mode,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             busy,
    output logic             done
`ifdef SYNC_DOWN_TIMER_CASCADE_EN
    ,
    output logic             tc_early
`endif
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             mode_q, mode_d;
    logic             tc_q, tc_d;
    logic [WIDTH-1:0] dec;
    logic             is_one;

    down_next #(.WIDTH(WIDTH)) u_next (
        .cnt_i    (q_q),
        .nxt_o    (dec),
        .is_one_o (is_one)
    );

    // Next state: load wins, otherwise count down while running and enabled.
    always_comb begin
        state_d  = state_q;
        q_d      = q_q;
        reload_d = reload_q;
        mode_d   = mode_q;
        tc_d     = 1'b0;
        if (load) begin
            q_d      = load_val;
            reload_d = load_val;
            mode_d   = mode;
            state_d  = (load_val != '0) ? RUN : IDLE;
        end else if (state_q == RUN && en) begin
            tc_d    = is_one;
            q_d     = !is_one ? dec : (mode_q == MODE_PERIODIC) ? reload_q : '0;
            state_d = (is_one && mode_q != MODE_PERIODIC) ? DONE : RUN;
        end
    end

    // State and datapath registers, cleared immediately by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            q_q      <= '0;
            reload_q <= '0;
            mode_q   <= 1'b0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            reload_q <= reload_d;
            mode_q   <= mode_d;
            tc_q     <= tc_d;
        end
    end

    assign q    = q_q;
    assign tc   = tc_q;
    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

`ifdef SYNC_DOWN_TIMER_CASCADE_EN
    assign tc_early = (state_q == RUN) & en & is_one & ~load;
`endif

endmodule

// File: tb/tb_sync_down_timer.sv
// tb_sync_down_timer: directed self-checking bench for sync_down_timer
module tb_sync_down_timer;

    logic       clk = 1'b0;
    logic       rst, en, load, mode;
    logic [3:0] load_val;
    logic [3:0] q;
    logic       tc, busy, done;
    int         n_checks = 0;
    int         n_errors = 0;
    int         tc_cnt;
    int         q_exp [8] = '{4, 4, 4, 3, 2, 2, 1, 0};
    int         en_pat [8] = '{1, 0, 0, 1, 1, 0, 1, 1};

`ifdef SYNC_DOWN_TIMER_CASCADE_EN
    logic       tc_early;
    logic       en_c, load_c;
    logic [3:0] lo_q, hi_q;
    logic       lo_tc, lo_busy, lo_done, lo_early;
    logic       hi_tc, hi_busy, hi_done, hi_early;
    logic       early_prev;
`endif

    always #5 clk = ~clk;

    sync_down_timer #(.WIDTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .mode     (mode),
        .q        (q),
        .tc       (tc),
        .busy     (busy),
        .done     (done)
`ifdef SYNC_DOWN_TIMER_CASCADE_EN
        ,
        .tc_early (tc_early)
`endif
    );

`ifdef SYNC_DOWN_TIMER_CASCADE_EN
    sync_down_timer #(.WIDTH(4)) u_lo (
        .clk(clk), .rst(rst), .en(en_c), .load(load_c), .load_val(4'd3), .mode(1'b1),
        .q(lo_q), .tc(lo_tc), .busy(lo_busy), .done(lo_done), .tc_early(lo_early)
    );
    sync_down_timer #(.WIDTH(4)) u_hi (
        .clk(clk), .rst(rst), .en(lo_early), .load(load_c), .load_val(4'd2), .mode(1'b0),
        .q(hi_q), .tc(hi_tc), .busy(hi_busy), .done(hi_done), .tc_early(hi_early)
    );
`endif

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int v, input logic m);
        load     = 1'b1;
        load_val = 4'(v);
        mode     = m;
        step();
        load     = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; load = 1'b0; mode = 1'b0; load_val = '0;
`ifdef SYNC_DOWN_TIMER_CASCADE_EN
        en_c = 1'b0; load_c = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_q", int'(q), 0);
        check("rst_tc", int'(tc), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);

        en = 1'b1;
        do_load(9, 1'b0);
        check("mid_load_q", int'(q), 9);
        check("mid_load_busy", int'(busy), 1);
        repeat (3) step();
        check("mid_q", int'(q), 6);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_q", int'(q), 0);
        check("async_rst_tc", int'(tc), 0);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_done", int'(done), 0);
        rst = 1'b0;
        step();
        check("idle_after_rst_q", int'(q), 0);
        check("idle_after_rst_busy", int'(busy), 0);

        do_load(3, 1'b0);
        check("os_q3", int'(q), 3);
        check("os_tc3", int'(tc), 0);
        step();
        check("os_q2", int'(q), 2);
        check("os_tc2", int'(tc), 0);
        step();
        check("os_q1", int'(q), 1);
        check("os_tc1", int'(tc), 0);
        step();
        check("os_q0", int'(q), 0);
        check("os_tc0", int'(tc), 1);
        check("os_done", int'(done), 1);
        check("os_busy", int'(busy), 0);
        for (int i = 0; i < 10; i++) begin
            step();
            check("os_hold_q", int'(q), 0);
            check("os_hold_tc", int'(tc), 0);
            check("os_hold_done", int'(done), 1);
        end

        do_load(4, 1'b1);
        check("per_q_load", int'(q), 4);
        tc_cnt = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            check("per_q", int'(q), (k % 4 == 0) ? 4 : 4 - k % 4);
            check("per_tc", int'(tc), (k % 4 == 0) ? 1 : 0);
            check("per_busy", int'(busy), 1);
            tc_cnt += int'(tc);
        end
        check("per_tc_count", tc_cnt, 3);

        do_load(5, 1'b0);
        check("gate_q_load", int'(q), 5);
        for (int i = 0; i < 8; i++) begin
            en = en_pat[i][0];
            step();
            check("gate_q", int'(q), q_exp[i]);
            check("gate_tc", int'(tc), (i == 7) ? 1 : 0);
        end
        check("gate_done", int'(done), 1);

        en = 1'b1;
        do_load(2, 1'b0);
        step();
        check("coll_pre_q", int'(q), 1);
        do_load(7, 1'b0);
        check("coll_q", int'(q), 7);
        check("coll_tc", int'(tc), 0);
        check("coll_busy", int'(busy), 1);
        step();
        check("coll_next_q", int'(q), 6);
        check("coll_next_tc", int'(tc), 0);

        do_load(0, 1'b1);
        check("zero_q", int'(q), 0);
        check("zero_busy", int'(busy), 0);
        check("zero_done", int'(done), 0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("zero_tc", int'(tc), 0);
            check("zero_busy_hold", int'(busy), 0);
        end

        do_load(1, 1'b1);
        check("r1_q", int'(q), 1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("r1_q_run", int'(q), 1);
            check("r1_tc", int'(tc), 1);
        end
        en = 1'b0;
        step();
        check("r1_tc_off", int'(tc), 0);
        check("r1_q_hold", int'(q), 1);

`ifdef SYNC_DOWN_TIMER_CASCADE_EN
        load_c = 1'b1;
        step();
        load_c = 1'b0;
        check("cas_lo_q", int'(lo_q), 3);
        check("cas_hi_q", int'(hi_q), 2);
        en_c = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            #1;
            check("cas_early", int'(lo_early), (lo_q == 4'd1) ? 1 : 0);
            early_prev = lo_early;
            step();
            check("cas_lo_tc", int'(lo_tc), int'(early_prev));
            check("cas_hi_tc", int'(hi_tc), (k == 6) ? 1 : 0);
        end
        check("cas_hi_done", int'(hi_done), 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
